my_cic_interp: RTL and testbench
================================

# my_cic_interp

Single-section-family CIC interpolator, the transmit-side counterpart of the team's CIC decimator. It accepts s16,15 samples at the low rate, once every R enabled clocks, and produces full-precision output on every enabled high-rate clock. It sits between the baseband sample source and the DAC/upconversion path. `ce_in` tells upstream when a sample is taken and `ce_out` qualifies each output.

## Interface
- `IN_W`, 16, input width (s16,15).
- `R`, 5, interpolation factor, legal 2..16.
- `N`, 3, number of comb and integrator sections, legal 1..4; differential delay fixed at 1.
- `OUT_W`, 21, output/internal width; must be ≥ IN_W + ceil(log2(R^(N-1))).
- `clk`  in  1  single clock, rising edge.
- `syn_rst_n`  in  1  asynchronous, active-low reset.
- `clk_enable`  in  1  high-rate enable; all state advances only when high.
- `cic_in`  in  IN_W  signed sample; sampled only when `ce_in`=1.
- `ce_in`  out  1  combinational phase-0 strobe: `cur_count`==0 and `clk_enable`=1.
- `cic_out`  out  OUT_W  signed output (sfixOUT_W_En15), registered.
- `ce_out`  out  1  registered copy of `clk_enable`; marks a new `cic_out`.

## Operation
- **Phase counter:** `cur_count` is 4 bits and counts 0..R-1 on enabled clocks, wrapping R-1→0. It holds when `clk_enable`=0.
- **Comb chain (low rate):** N stages, each with one delay register `diff_j`. The chain is combinational: stage j output = in_j − `diff_j`. All `diff_j` load their stage input only on `ce_in`. Stage 1 input is `cic_in` sign-extended to OUT_W.
- **Zero-stuffer:** `up` = comb output when `ce_in`=1, otherwise 0.
- **Integrator chain (high rate):** N registers that update on every enabled clock.
  - `int_1` <= `int_1` + `up`.
  - `int_k` <= `int_k` + `int_(k-1)`, using the registered previous stage.
- **Output register:** `cic_out` <= `int_N` (or its rounded form, see Configuration) on each enabled clock.
- **Arithmetic:** all internal arithmetic is OUT_W two's complement with intentional wrap. There is no saturation inside the chain; modular wrap is exact for CIC.
- **DC gain:** R^(N-1), which is 25 for the defaults.
- **Reset:** asserting `syn_rst_n` low asynchronously clears `cur_count`, all `diff_j`, all `int_k`, `cic_out` and `ce_out` to 0.
- **Reset mid-operation:** the pipeline is discarded with no partial output. The first enabled clock after release is phase 0 (`ce_in`=1).
- **`clk_enable` low:** every register freezes, including the counter, `diff_j`, `int_k` and `cic_out`. `ce_out` goes 0 one clock later. Resuming continues exactly where the block stopped.

## Timing
- **Latency:** a sample taken on enabled clock t first affects `cic_out` after enabled clock t+N+1.
  - `int_1` at t+1, `int_N` at t+N, `cic_out` register at t+N+1.
  - Defaults: 4 enabled clocks.
- **Input rate:** exactly one input per R enabled clocks. `cic_in` need only be valid on `ce_in` cycles.
- **Output rate:** one output per enabled clock. `ce_out` is high in the cycle in which each new `cic_out` value is first visible.
- **Impulse response length:** N(R−1)+1 outputs. Defaults: 13.

## Configuration
- `CIC_INTERP_ROUND_EN` defined:
  - `cic_out` is IN_W wide.
  - The value is `int_N` with its (OUT_W−IN_W) LSBs dropped, rounded half-up, then saturated to [−2^(IN_W−1), 2^(IN_W−1)−1].
  - Gain is R^(N-1)/2^(OUT_W−IN_W), which is 25/32 for the defaults.
  - Latency is unchanged; rounding is done before the output register.
- `CIC_INTERP_ROUND_EN` not defined: `cic_out` is OUT_W full precision, as described above.

## Test plan
- **Impulse:** defaults, `clk_enable`=1, `cic_in`=1 on one `ce_in` then 0. `cic_out` is 0,0,0, then 1,3,6,10,15,18,19,18,15,10,6,3,1, then 0 (sum 125). The first nonzero value appears 4 clocks after the sample clock.
- **DC step:** `cic_in`=32767 held. `cic_out` settles to 819175 after 13+4 clocks and holds constant. Negative full scale, −32768, settles to −819200.
- **N=1, R=5:** `cic_in` sequence 100, −200. `cic_out` is 100 for 5 clocks, then −200 for 5 clocks (zero-order hold), 2 clocks after each sample.
- **Enable gaps:** repeat the impulse test with `clk_enable` toggling 1,0,1,1,0….
  - Output values and count of `ce_out` pulses are identical to the gap-free run.
  - `cic_out` is stable while `clk_enable`=0.
  - `ce_in` fires every 5th enabled clock.
- **Reset mid-stream:** pulse `syn_rst_n` low asynchronously (between edges) during the step test.
  - All outputs read 0 immediately.
  - After release, `ce_in` is high on the first enabled clock.
  - Step response restarts from zero.
- **`CIC_INTERP_ROUND_EN`:**
  - Step 32767 gives `cic_out`=25599.
  - Step −32768 gives −25600.
  - Impulse 16 gives 1,2,3,5,8,9,10,9,8,5,3,2,1.

Source files
------------

// File: rtl/my_cic_interp_if.sv
// Sample-stream bundle for my_cic_interp: enable, low-rate input, phase strobe and output.
// CIC_INTERP_ROUND_EN narrows cic_out to IN_W, matching the rounded output of the block.
interface my_cic_interp_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 21
);
`ifdef CIC_INTERP_ROUND_EN
    localparam int PORT_W = IN_W;
`else
    localparam int PORT_W = OUT_W;
`endif

    logic                     clk_enable;
    logic signed [IN_W-1:0]   cic_in;
    logic                     ce_in;
    logic signed [PORT_W-1:0] cic_out;
    logic                     ce_out;

    modport master (
        output clk_enable,
        output cic_in,
        input  ce_in,
        input  cic_out,
        input  ce_out
    );

    modport slave (
        input  clk_enable,
        input  cic_in,
        output ce_in,
        output cic_out,
        output ce_out
    );
endinterface

// File: rtl/my_cic_interp.sv
// N-stage CIC interpolator by R (differential delay 1), full-precision wrap-around arithmetic.
// Define CIC_INTERP_ROUND_EN for an IN_W-wide output: LSBs dropped, rounded half-up, saturated.
module my_cic_interp #(
    parameter int IN_W  = 16,
    parameter int R     = 5,
    parameter int N     = 3,
    parameter int OUT_W = 21
) (
    input  logic         clk,
    input  logic         syn_rst_n,
    my_cic_interp_if.slave bus
);

    localparam logic [3:0] LAST_PHASE = 4'(R - 1);

`ifdef CIC_INTERP_ROUND_EN
    localparam int PORT_W = IN_W;
    localparam int DROP   = OUT_W - IN_W;
    localparam logic [OUT_W:0] HALF = {{OUT_W{1'b0}}, 1'b1} << (DROP - 1);

    // Half-up rounding of the dropped LSBs, then clamp to the IN_W signed range.
    function automatic logic signed [IN_W-1:0] round_sat(input logic signed [OUT_W-1:0] v);
        logic [OUT_W:0] biased;
        logic [IN_W:0]  q;
        biased = {v[OUT_W-1], v} + HALF;
        q      = biased[OUT_W:DROP];
        if (q[IN_W] != q[IN_W-1]) begin
            round_sat = q[IN_W] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
        end else begin
            round_sat = q[IN_W-1:0];
        end
    endfunction
`else
    localparam int PORT_W = OUT_W;
`endif

    logic [3:0]               cur_count_r;
    logic signed [OUT_W-1:0]  diff_r     [N];
    logic signed [OUT_W-1:0]  stage_in_s [N];
    logic signed [OUT_W-1:0]  int_r      [N];
    logic signed [OUT_W-1:0]  in_ext_s;
    logic signed [OUT_W-1:0]  comb_out_s;
    logic signed [OUT_W-1:0]  up_s;
    logic signed [PORT_W-1:0] out_val_s;
    logic signed [PORT_W-1:0] cic_out_r;
    logic                     ce_in_s;
    logic                     ce_out_r;

    assign ce_in_s  = (cur_count_r == 4'd0) && bus.clk_enable;
    assign in_ext_s = OUT_W'(bus.cic_in);
    assign up_s     = ce_in_s ? comb_out_s : {OUT_W{1'b0}};

    // Low-rate comb chain: each stage subtracts its delayed input.
    always_comb begin : comb_chain
        logic signed [OUT_W-1:0] acc_v;
        acc_v = in_ext_s;
        for (int j = 0; j < N; j++) begin
            stage_in_s[j] = acc_v;
            acc_v         = acc_v - diff_r[j];
        end
        comb_out_s = acc_v;
    end

    // Output value selection (full precision or rounded/saturated).
    always_comb begin
`ifdef CIC_INTERP_ROUND_EN
        out_val_s = round_sat(int_r[N-1]);
`else
        out_val_s = int_r[N-1];
`endif
    end

    // Phase counter 0..R-1 over enabled clocks.
    always_ff @(posedge clk or negedge syn_rst_n) begin
        if (!syn_rst_n) begin
            cur_count_r <= 4'd0;
        end else if (bus.clk_enable) begin
            cur_count_r <= (cur_count_r == LAST_PHASE) ? 4'd0 : cur_count_r + 4'd1;
        end
    end

    // Comb delay registers load only on the input phase.
    always_ff @(posedge clk or negedge syn_rst_n) begin
        if (!syn_rst_n) begin
            for (int j = 0; j < N; j++) diff_r[j] <= {OUT_W{1'b0}};
        end else if (ce_in_s) begin
            for (int j = 0; j < N; j++) diff_r[j] <= stage_in_s[j];
        end
    end

    // High-rate integrators; each stage accumulates the registered previous stage.
    always_ff @(posedge clk or negedge syn_rst_n) begin
        if (!syn_rst_n) begin
            for (int k = 0; k < N; k++) int_r[k] <= {OUT_W{1'b0}};
        end else if (bus.clk_enable) begin
            int_r[0] <= int_r[0] + up_s;
            for (int k = 1; k < N; k++) int_r[k] <= int_r[k] + int_r[k-1];
        end
    end

    // Output register and its qualifier.
    always_ff @(posedge clk or negedge syn_rst_n) begin
        if (!syn_rst_n) begin
            cic_out_r <= {PORT_W{1'b0}};
            ce_out_r  <= 1'b0;
        end else begin
            ce_out_r <= bus.clk_enable;
            if (bus.clk_enable) begin
                cic_out_r <= out_val_s;
            end
        end
    end

    assign bus.ce_in   = ce_in_s;
    assign bus.cic_out = cic_out_r;
    assign bus.ce_out  = ce_out_r;

endmodule

// File: tb/tb_my_cic_interp.sv
// Self-checking bench for my_cic_interp: convolution model of the interpolator plus literal
// impulse/step expectations; honours CIC_INTERP_ROUND_EN.
module tb_my_cic_interp;

    localparam int IN_W  = 16;
    localparam int R     = 5;
    localparam int N     = 3;
    localparam int OUT_W = 21;
    localparam int HL    = N * (R - 1) + 1;
    localparam int MAXE  = 4096;

`ifdef CIC_INTERP_ROUND_EN
    localparam int     AMP    = 16;
    localparam longint STEP_P = 25599;
    localparam longint STEP_N = -25600;
    longint imp_lit [0:12] = '{1, 2, 3, 5, 8, 9, 10, 9, 8, 5, 3, 2, 1};
`else
    localparam int     AMP    = 1;
    localparam longint STEP_P = 819175;
    localparam longint STEP_N = -819200;
    longint imp_lit [0:12] = '{1, 3, 6, 10, 15, 18, 19, 18, 15, 10, 6, 3, 1};
`endif

    logic clk       = 1'b0;
    logic syn_rst_n = 1'b0;

    my_cic_interp_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    my_cic_interp #(.IN_W(IN_W), .R(R), .N(N), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .syn_rst_n (syn_rst_n),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint h     [0:63];
    int     x_up  [0:MAXE-1];
    int     e_cnt = 0;
    bit     last_en = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output after enabled clock e: impulse response convolved with the zero-stuffed input.
    function automatic longint model_y(input int e);
        longint acc;
        int     idx;
        acc = 0;
        for (int k = 0; k < HL; k++) begin
            idx = e - N - k;
            if (idx >= 0) acc += h[k] * longint'(x_up[idx]);
        end
        acc = acc & ((longint'(1) << OUT_W) - 1);
        if (acc >= (longint'(1) << (OUT_W - 1))) acc -= (longint'(1) << OUT_W);
`ifdef CIC_INTERP_ROUND_EN
        acc = (acc + (longint'(1) << (OUT_W - IN_W - 1))) >>> (OUT_W - IN_W);
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
`endif
        return acc;
    endfunction

    task automatic step(input bit en, input int x);
        @(negedge clk);
        check("ce_out", bus.ce_out, last_en);
        check("cic_out", bus.cic_out, model_y(e_cnt - 1));
        bus.clk_enable = en;
        bus.cic_in     = x[IN_W-1:0];
        #1;
        check("ce_in", bus.ce_in, (en && (e_cnt % R == 0)));
        @(posedge clk);
        if (en) begin
            x_up[e_cnt] = (e_cnt % R == 0) ? x : 0;
            e_cnt++;
        end
        last_en = en;
        #1;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 syn_rst_n = 1'b0;
        #1;
        check("rst_cic_out", bus.cic_out, 0);
        check("rst_ce_out", bus.ce_out, 0);
        e_cnt   = 0;
        last_en = 1'b0;
        @(posedge clk);
        #2 syn_rst_n = 1'b1;
    endtask

    initial begin
        longint tmp [0:63];
        int     len;
        int     nz;
        int     x;
        int     r;
        bit     pat [0:4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        for (int i = 0; i < 64; i++) h[i] = 0;
        for (int i = 0; i < R; i++) h[i] = 1;
        len = R;
        for (int s = 2; s <= N; s++) begin
            for (int i = 0; i < 64; i++) tmp[i] = 0;
            for (int i = 0; i < len + R - 1; i++)
                for (int j = 0; j < R; j++)
                    if (i - j >= 0 && i - j < len) tmp[i] += h[i - j];
            len = len + R - 1;
            for (int i = 0; i < 64; i++) h[i] = tmp[i];
        end

        bus.clk_enable = 1'b0;
        bus.cic_in     = '0;

        // Impulse, gap-free, against the literal response.
        async_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, (i == 0) ? AMP : 0);
            check("imp_lit", bus.cic_out, (i >= 3 && i < 3 + HL) ? imp_lit[i - 3] : 0);
        end

        // DC steps at both full-scale extremes.
        async_reset();
        for (int i = 0; i < 25; i++) step(1'b1, 32767);
        check("step_pos", bus.cic_out, STEP_P);
        async_reset();
        for (int i = 0; i < 25; i++) step(1'b1, -32768);
        check("step_neg", bus.cic_out, STEP_N);

        // Reset in the middle of a step response, then restart.
        async_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 32767);
        async_reset();
        for (int i = 0; i < 25; i++) step(1'b1, 32767);
        check("step_restart", bus.cic_out, STEP_P);

        // Impulse with enable gaps: same nonzero output count.
        async_reset();
        nz = 0;
        for (int i = 0; i < 60; i++) begin
            step(pat[i % 5], (e_cnt == 0) ? AMP : 0);
            if (bus.ce_out && bus.cic_out != 0) nz++;
        end
        check("gap_nonzero_count", nz, HL);

        // Randomized input and enable, three reset segments.
        for (int seg = 0; seg < 3; seg++) begin
            async_reset();
            for (int i = 0; i < 400; i++) begin
                r = int'($urandom_range(0, 9));
                if (r == 0)      x = 32767;
                else if (r == 1) x = -32768;
                else             x = int'($urandom_range(0, 65535)) - 32768;
                step($urandom_range(0, 3) != 0, x);
            end
        end
        step(1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
